// File: rtl/md_sequencer_pkg.sv
// Shared MULTDIVControl codes, FSM state encodings and small op-decode helpers
// for the multiply/divide sequencer.
package md_sequencer_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    MD_MULT  = 4'd0,
    MD_MULTU = 4'd1,
    MD_DIV   = 4'd2,
    MD_DIVU  = 4'd3,
    MD_MTHI  = 4'd4,
    MD_MTLO  = 4'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_arith_op(input logic [3:0] op);
    return (op <= MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit multiply/divide result generator; the sequencer decides
// when the result is committed to HI/LO.
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi_res,
  output logic [DATA_W-1:0] lo_res,
  output logic              div_zero
);

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  logic signed [2*DATA_W-1:0] sprod;
  logic        [2*DATA_W-1:0] uprod;
  logic                       signed_div;
  logic        [DATA_W-1:0]   abs_a;
  logic        [DATA_W-1:0]   abs_b;
  logic        [DATA_W-1:0]   divisor;
  logic        [DATA_W-1:0]   q_mag;
  logic        [DATA_W-1:0]   r_mag;

  assign sprod = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
  assign uprod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  // Signed division runs on magnitudes so that 0x80000000 / -1 wraps cleanly
  // instead of relying on simulator overflow behaviour.
  assign signed_div = (op == MD_DIV);
  assign abs_a      = neg_if(a, signed_div & a[DATA_W-1]);
  assign abs_b      = neg_if(b, signed_div & b[DATA_W-1]);
  assign div_zero   = (b == '0);
  assign divisor    = div_zero ? DATA_W'(1) : abs_b;
  assign q_mag      = abs_a / divisor;
  assign r_mag      = abs_a % divisor;

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    case (op)
      MD_MULT: begin
        hi_res = sprod[2*DATA_W-1:DATA_W];
        lo_res = sprod[DATA_W-1:0];
      end
      MD_MULTU: begin
        hi_res = uprod[2*DATA_W-1:DATA_W];
        lo_res = uprod[DATA_W-1:0];
      end
      MD_DIV: begin
        lo_res = neg_if(q_mag, a[DATA_W-1] ^ b[DATA_W-1]);
        hi_res = neg_if(r_mag, a[DATA_W-1]);
      end
      MD_DIVU: begin
        lo_res = q_mag;
        hi_res = r_mag;
      end
      default: begin
        hi_res = '0;
        lo_res = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: owns HI/LO, runs fixed-latency operations
// and raises the D-stage stall request for following multdiv instructions.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [3:0]  E_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_md_instr,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  md_state_e   state, state_n;
  logic [3:0]  count;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_res, lo_res;
  logic        div_zero;
  logic        start_acc;
  logic        done;
  logic        idle_move;

  md_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  assign busy      = (state == ST_BUSY);
  assign stall_req = D_md_instr & (E_start | busy);
  assign HI        = hi_q;
  assign LO        = lo_q;

  assign start_acc = (state == ST_IDLE) & E_start & is_arith_op(E_op);
  assign done      = (state == ST_BUSY) & (count == 4'd1);
  assign idle_move = (state == ST_IDLE) & ~E_start;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start_acc) state_n = ST_BUSY;
      ST_BUSY: if (count == 4'd1) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      if (start_acc) begin
        op_q  <= E_op;
        a_q   <= E_rs;
        b_q   <= E_rt;
        count <= is_div_op(E_op) ? DIV_CNT : MULT_CNT;
      end else if (busy) begin
        count <= count - 4'd1;
      end
      // A zero divisor still occupies the full latency but leaves HI/LO alone.
      if (done) begin
        if (!(is_div_op(op_q) && div_zero)) begin
          hi_q <= hi_res;
          lo_q <= lo_res;
        end
      end else if (idle_move && (E_op == MD_MTHI)) begin
        hi_q <= E_rs;
      end else if (idle_move && (E_op == MD_MTLO)) begin
        lo_q <= E_rs;
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: stimulus queues expected HI/LO/latency,
// a monitor checks them whenever busy falls.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_start;
  logic [3:0]  E_op;
  logic [31:0] E_rs, E_rt;
  logic        D_md_instr;
  logic        busy, stall_req;
  logic [31:0] HI, LO;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic chk_en = 1'b1;
  logic prev_busy = 1'b0;
  int   run_len = 0;

  localparam logic [3:0] NOP = 4'hF;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_start    (E_start),
    .E_op       (E_op),
    .E_rs       (E_rs),
    .E_rt       (E_rt),
    .D_md_instr (D_md_instr),
    .busy       (busy),
    .stall_req  (stall_req),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a completed operation is marked by busy falling.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      run_len++;
    end else if (prev_busy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL completion: got unexpected end of busy, expected none");
      end else begin
        e = exp_q.pop_front();
        check("result_hi", HI, e.hi);
        check("result_lo", LO, e.lo);
        check("busy_len", 32'(run_len), e.cyc);
      end
      run_len = 0;
    end
    prev_busy = (busy === 1'b1);
  end

  always @(posedge clk) begin
    if (chk_en && !reset)
      assert (!(busy && (E_start || E_op == 4'd4 || E_op == 4'd5)))
      else begin
        errors++;
        $display("FAIL busy_issue: got command while busy, expected none");
      end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk); #1;
    E_start = (op <= 4'd3);
    E_op    = op;
    E_rs    = rs;
    E_rt    = rt;
    @(posedge clk); #1;
    E_start = 1'b0;
    E_op    = NOP;
  endtask

  task automatic push(input logic [31:0] hi, input logic [31:0] lo, input int cyc);
    exp_t e;
    e.hi = hi; e.lo = lo; e.cyc = 32'(cyc);
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy after %0d cycles, expected idle", n);
    end
  endtask

  initial begin
    reset = 1'b1; E_start = 1'b0; E_op = NOP; E_rs = '0; E_rt = '0; D_md_instr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_stall", 32'(stall_req), 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    push(32'hFFFFFFFF, 32'hFFFFFFF1, 5);
    issue(4'd0, 32'hFFFFFFFD, 32'd5);
    wait_idle();

    push(32'd1, 32'd3, 10);
    issue(4'd3, 32'd7, 32'd2);
    wait_idle();

    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(4'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle();

    issue(4'd4, 32'h12345678, 32'd0);
    @(negedge clk);
    check("mthi_hi", HI, 32'h12345678);
    check("mthi_lo", LO, 32'hFFFFFFFD);
    check("mthi_busy", 32'(busy), 32'd0);
    issue(4'd5, 32'hCAFEBABE, 32'd0);
    @(negedge clk);
    check("mtlo_lo", LO, 32'hCAFEBABE);
    check("mtlo_hi", HI, 32'h12345678);

    push(32'h12345678, 32'hCAFEBABE, 10);
    issue(4'd2, 32'd5, 32'd0);
    wait_idle();

    push(32'd0, 32'h80000000, 10);
    issue(4'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();

    // Stall covers the start cycle T and the busy cycles T+1..T+5.
    push(32'd0, 32'd12, 5);
    @(posedge clk); #1;
    D_md_instr = 1'b1; E_start = 1'b1; E_op = 4'd0; E_rs = 32'd3; E_rt = 32'd4;
    @(negedge clk);
    check("stall_t0", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    E_start = 1'b0; E_op = NOP;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("stall_t%0d", i), 32'(stall_req), (i <= 5) ? 32'd1 : 32'd0);
    end
    D_md_instr = 1'b0;

    push(32'd1, 32'd0, 5);
    @(posedge clk); #1;
    E_start = 1'b1; E_op = 4'd1; E_rs = 32'h00010000; E_rt = 32'h00010000;
    @(negedge clk);
    check("nostall_t0", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    E_start = 1'b0; E_op = NOP;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check($sformatf("nostall_t%0d", i), 32'(stall_req), 32'd0);
    end
    wait_idle();

    // Reset asserted in the third busy cycle aborts the divide.
    push(32'd0, 32'd0, 3);
    issue(4'd2, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);

    push(32'd1, 32'hFFFFFFFE, 5);
    issue(4'd1, 32'hFFFFFFFF, 32'd2);
    wait_idle();

    // A start forced in while busy must be ignored.
    push(32'd2, 32'd14, 10);
    issue(4'd2, 32'd100, 32'd7);
    @(posedge clk); #1;
    chk_en = 1'b0; E_start = 1'b1; E_op = 4'd0; E_rs = 32'd2; E_rt = 32'd3;
    @(posedge clk); #1;
    E_start = 1'b0; E_op = NOP; chk_en = 1'b1;
    wait_idle();

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL pending: got %0d outstanding results, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Sequencing controller for the multiply/divide resource that sits beside the ALU in E stage. Accepts start and op commands decoded by the control unit and owns the HI and LO registers. Runs fixed-latency multiply or divide operations and produces the busy/stall request that the hazard unit uses to hold any D-stage multdiv instruction. mfhi/mflo read HI and LO directly from this block.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1-15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1-15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
E_start  in  1  E-stage instruction is mult/multu/div/divu
E_op  in  4  MULTDIVControl code: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
E_rs  in  32  forwarded rs value (dividend / multiplicand / mthi-mtlo source)
E_rt  in  32  forwarded rt value (divisor / multiplier)
D_md_instr  in  1  D-stage instruction is any multdiv instruction (multdiv_INSTR)
busy  out  1  operation in progress
stall_req  out  1  hold the D stage
HI  out  32  current HI register
LO  out  32  current LO register

Behaviour:
- Reset (synchronous; overrides all other inputs in the same cycle): state=IDLE, count=0, HI=0, LO=0, busy=0, operand latches=0. A reset during BUSY aborts the operation, and HI/LO are still cleared.
- FSM with two states, IDLE and BUSY. busy = (state==BUSY).
- IDLE, E_start=1 with E_op in 0..3:
  - Latch E_rs, E_rt and E_op.
  - Load count with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
  - Go to BUSY.
  - Start sampled at the edge ending cycle T means busy is high in cycles T+1..T+N.
- IDLE, E_op=4 (MTHI) or 5 (MTLO) with E_start=0: HI (or LO) <= E_rs at the next edge. This takes one cycle, and busy is not asserted.
- E_op codes 6..15, or E_start=1 with E_op>3: no effect.
- BUSY: count decrements every cycle. On the edge where count==1:
  - HI/LO <= result.
  - state <= IDLE.
  - New HI/LO are visible in cycle T+N+1.
- Results are computed from the latched operands, never from the live inputs:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero, HI = remainder with the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned quotient and remainder.
  - Divisor==0 (DIV/DIVU): HI and LO stay unchanged at completion, and busy still lasts the full DIV_CYCLES.
- E_start, MTHI or MTLO arriving while BUSY is ignored. stall_req prevents this in a correct pipeline; the bench checks it with an assertion.
- stall_req = D_md_instr & (E_start | busy). This is combinational, so it covers the cycle in which start is in E.
- HI/LO outputs are plain register values; there is no bypass of the result being written in the same cycle.

Decomposition:
- Shared constants file: MULTDIVControl codes (MULT..MTLO) and the FSM state encodings. Reuse the MULTDIVControl codes already defined for the control unit; do not define new ones.
- One natural sub-module, md_arith: a purely combinational 64-bit result generator with inputs op, a, b and outputs hi_res, lo_res, div_zero.
- md_sequencer keeps the FSM, counter, operand latches, HI/LO and the stall logic.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU rs=7, rt=2 -> busy 10 cycles; then LO=1? No: LO=3, HI=1. DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI rs=0x12345678, then DIV rs=5, rt=0 -> HI still 0x12345678 after 10 busy cycles, busy drops on schedule. Separately, DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- D_md_instr=1 held with MULT start at cycle T -> stall_req high in cycles T..T+5, low at T+6. With D_md_instr=0 throughout -> stall_req stays 0.
- Reset at the 3rd busy cycle of a DIV -> next cycle busy=0, HI=LO=0. A fresh MULTU rs=0xFFFFFFFF, rt=2 afterwards -> HI=1, LO=0xFFFFFFFE.
- E_start with MULT while BUSY (forced, assertion disabled) -> ignored; the original operation completes with its original result and timing.
